dll_tap_ctrl: RTL
=================

Name: dll_tap_ctrl

Overview:
Closed-loop tap controller for the inverter-pair delay chain in the PLL/DLL path. It selects the active tap from phase-detector UP/DN votes so that the delayed clock aligns with the reference.
- Per-adjustment flow: settle after each tap change, collect votes over a fixed window, then step the tap by ±1 or count an in-band window.
- Asserts locked after enough consecutive in-band windows and keeps tracking afterwards.

Parameters:
N_TAPS, 10, number of selectable taps (legal tap_sel 0..N_TAPS-1)
TAP_W, 4, tap_sel width; must satisfy 2**TAP_W >= N_TAPS
INIT_TAP, 5, tap loaded on reset and on cal_start
SETTLE_CYC, 8, idle cycles after a tap change before voting
WIN_CYC, 16, vote window length in cycles
DEADBAND, 2, |up_cnt - dn_cnt| <= DEADBAND counts as in-band
LOCK_WINS, 4, consecutive in-band windows required for lock

Ports:
clk  in  1  single clock
rst_n  in  1  reset; asynchronous, active-low
cal_start  in  1  one-cycle pulse: start or restart calibration
pd_up  in  1  phase detector says delay too short; synchronous to clk
pd_dn  in  1  phase detector says delay too long; synchronous to clk
tap_sel  out  TAP_W  selected delay tap
locked  out  1  alignment achieved
busy  out  1  high in any state other than IDLE
sat_err  out  1  sticky: adjustment requested beyond tap range

Behaviour:
- Reset (async, rst_n=0) puts the block in a known state. All outputs and counters are registered.
  - state=IDLE, tap_sel=INIT_TAP, locked=0, busy=0, sat_err=0.
  - All counters cleared.
- States: IDLE, SETTLE, VOTE, DECIDE.
- IDLE:
  - Waits for cal_start.
  - On cal_start: tap_sel<=INIT_TAP, locked<=0, sat_err<=0, lock counter<=0, then go to SETTLE.
- SETTLE:
  - Counts SETTLE_CYC cycles; pd inputs are ignored.
  - Goes to VOTE on the cycle after the count completes.
- VOTE:
  - Runs for exactly WIN_CYC cycles.
  - Per cycle: up_cnt++ if pd_up & !pd_dn; dn_cnt++ if pd_dn & !pd_up.
  - Both or neither asserted: no count.
  - Counter width is clog2(WIN_CYC+1); counters cannot overflow.
- DECIDE (one cycle):
  - up_cnt > dn_cnt+DEADBAND:
    - if tap_sel < N_TAPS-1: tap_sel+1, lock counter cleared, locked<=0, go to SETTLE.
    - else: sat_err<=1, tap held, lock counter cleared, locked<=0, go to VOTE.
  - dn_cnt > up_cnt+DEADBAND: mirror of the up case.
    - if tap_sel > 0: tap_sel-1, lock counter cleared, locked<=0, go to SETTLE.
    - else: sat_err<=1, tap held, lock counter cleared, locked<=0, go to VOTE.
  - Otherwise in-band: lock counter increments (saturating at LOCK_WINS); locked<=1 when it reaches LOCK_WINS; go to VOTE.
  - Vote counters clear on DECIDE exit.
- Locked operation: the block never returns to IDLE by itself and tracks continuously. A single out-of-band window drops locked in the same DECIDE cycle.
- cal_start in any non-IDLE state: same action as from IDLE (restart at INIT_TAP, go to SETTLE); the partial window is discarded.
- Timing:
  - tap_sel changes only on the DECIDE→SETTLE transition.
  - Minimum tap-to-tap spacing = SETTLE_CYC+WIN_CYC+1 cycles.
- tap_sel never leaves 0..N_TAPS-1.

Optional Feature:
Macro DLL_TAP_OVERRIDE_EN.
- Defined: adds inputs tap_ovr_en (1) and tap_ovr_val (TAP_W).
  - While tap_ovr_en=1: tap_sel=min(tap_ovr_val, N_TAPS-1), state is forced to IDLE, locked=0, busy=0.
  - On release, tap_sel stays at the override value until the next cal_start.
- Undefined: the ports do not exist and behaviour is exactly as above.

Decomposition:
- Shared package dll_pkg holds:
  - state enum type (IDLE/SETTLE/VOTE/DECIDE);
  - default constants for N_TAPS, INIT_TAP, SETTLE_CYC, WIN_CYC, DEADBAND, LOCK_WINS;
  - a clog2 helper.
- One sub-module, dll_vote_window: WIN_CYC window counter plus up/dn vote counters with clear/enable. It outputs window_done, up_cnt and dn_cnt.
- The FSM, tap register and lock logic stay in the top.

Test Plan:
- Reset then cal_start, pd_up=1 constantly (defaults) → tap_sel 5→6→7→8→9 with 25-cycle spacing, then sat_err=1, tap_sel stays 9, locked=0.
- cal_start, pd_up/pd_dn alternating every cycle (8/8 votes) → tap_sel stays 5; locked=1 on the 4th DECIDE, i.e. 8+4*17 cycles after start.
- While locked, pd_dn=1 for one full window (0/16) → locked drops in that DECIDE cycle, tap_sel=4, state SETTLE.
- Balanced votes ±1 (9 up/7 dn, diff 2) → in-band; 10 up/6 dn (diff 4) → tap_sel increments.
- pd_up=pd_dn=1 for a whole window → 0/0 votes, in-band.
- cal_start mid-VOTE with tap_sel=8 → tap_sel=5 next cycle, sat_err cleared, SETTLE restarts.
- Async rst_n pulse mid-SETTLE, shorter than one clock period → outputs reset immediately.
- With DLL_TAP_OVERRIDE_EN, tap_ovr_val=12 → tap_sel=9, busy=0.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared types and defaults for the DLL tap controller.
// Also provides a constant-evaluable clog2 helper used to size counters.
package dll_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      VOTE   = 2'd2,
      DECIDE = 2'd3
   } dll_state_t;

   localparam int unsigned DEF_N_TAPS     = 10;
   localparam int unsigned DEF_TAP_W      = 4;
   localparam int unsigned DEF_INIT_TAP   = 5;
   localparam int unsigned DEF_SETTLE_CYC = 8;
   localparam int unsigned DEF_WIN_CYC    = 16;
   localparam int unsigned DEF_DEADBAND   = 2;
   localparam int unsigned DEF_LOCK_WINS  = 4;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = unsigned'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/dll_tap_ctrl_vote.sv
// Vote window for the DLL tap controller: a WIN_CYC-cycle window counter plus
// up/dn vote tallies. Counters hold their value while disabled and clear on clr.
module dll_vote_window
   import dll_pkg::*;
#(
   parameter int unsigned WIN_CYC = DEF_WIN_CYC,
   parameter int unsigned CW      = clog2(WIN_CYC + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic          pd_up,
   input  logic          pd_dn,
   output logic          window_done,
   output logic [CW-1:0] up_cnt,
   output logic [CW-1:0] dn_cnt
);

   localparam logic [CW-1:0] WIN_LAST = CW'(WIN_CYC - 1);

   logic [CW-1:0] win_cnt;

   // Done on the last enabled cycle, so that cycle's vote is still tallied.
   assign window_done = en && (win_cnt == WIN_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt <= '0;
         up_cnt  <= '0;
         dn_cnt  <= '0;
      end else if (clr) begin
         win_cnt <= '0;
         up_cnt  <= '0;
         dn_cnt  <= '0;
      end else if (en) begin
         win_cnt <= window_done ? '0 : win_cnt + CW'(1);
         if (pd_up && !pd_dn) up_cnt <= up_cnt + CW'(1);
         if (pd_dn && !pd_up) dn_cnt <= dn_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/dll_tap_ctrl.sv
// Closed-loop delay-chain tap controller: settle, vote, decide, step the tap.
// Optional manual tap override is compiled in with `define DLL_TAP_OVERRIDE_EN.
module dll_tap_ctrl
   import dll_pkg::*;
#(
   parameter int unsigned N_TAPS     = DEF_N_TAPS,
   parameter int unsigned TAP_W      = DEF_TAP_W,
   parameter int unsigned INIT_TAP   = DEF_INIT_TAP,
   parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int unsigned WIN_CYC    = DEF_WIN_CYC,
   parameter int unsigned DEADBAND   = DEF_DEADBAND,
   parameter int unsigned LOCK_WINS  = DEF_LOCK_WINS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cal_start,
   input  logic             pd_up,
   input  logic             pd_dn,
`ifdef DLL_TAP_OVERRIDE_EN
   input  logic             tap_ovr_en,
   input  logic [TAP_W-1:0] tap_ovr_val,
`endif
   output logic [TAP_W-1:0] tap_sel,
   output logic             locked,
   output logic             busy,
   output logic             sat_err,
   output dll_state_t       state_dbg
);

   localparam int unsigned CW = clog2(WIN_CYC + 1);
   localparam int unsigned SW = clog2(SETTLE_CYC + 1);
   localparam int unsigned LW = clog2(LOCK_WINS + 1);

   localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(N_TAPS - 1);
   localparam logic [TAP_W-1:0] TAP_INIT    = TAP_W'(INIT_TAP);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [LW-1:0]    LOCK_FULL   = LW'(LOCK_WINS);
   localparam logic [CW:0]      DB          = (CW + 1)'(DEADBAND);

   dll_state_t       state, state_nxt;
   logic [TAP_W-1:0] tap_nxt;
   logic             locked_nxt, sat_nxt;
   logic [LW-1:0]    lock_cnt, lock_cnt_nxt;
   logic [SW-1:0]    settle_cnt, settle_nxt;

   logic          window_done;
   logic [CW-1:0] up_cnt, dn_cnt;
   logic          vote_clr, vote_en;
   logic          want_up, want_dn;

   // Tallies are held through DECIDE and cleared as it exits.
   assign vote_clr = cal_start || (state != VOTE);
   assign vote_en  = (state == VOTE) && !cal_start;
   assign want_up  = {1'b0, up_cnt} > ({1'b0, dn_cnt} + DB);
   assign want_dn  = {1'b0, dn_cnt} > ({1'b0, up_cnt} + DB);
   assign state_dbg = state;

   dll_vote_window #(
      .WIN_CYC (WIN_CYC),
      .CW      (CW)
   ) u_vote (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (vote_clr),
      .en          (vote_en),
      .pd_up       (pd_up),
      .pd_dn       (pd_dn),
      .window_done (window_done),
      .up_cnt      (up_cnt),
      .dn_cnt      (dn_cnt)
   );

   always_comb begin
      state_nxt    = state;
      tap_nxt      = tap_sel;
      locked_nxt   = locked;
      sat_nxt      = sat_err;
      lock_cnt_nxt = lock_cnt;
      settle_nxt   = settle_cnt;
      if (cal_start) begin
         state_nxt    = SETTLE;
         tap_nxt      = TAP_INIT;
         locked_nxt   = 1'b0;
         sat_nxt      = 1'b0;
         lock_cnt_nxt = '0;
         settle_nxt   = '0;
      end else begin
         case (state)
            IDLE: ;
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state_nxt  = VOTE;
                  settle_nxt = '0;
               end else begin
                  settle_nxt = settle_cnt + SW'(1);
               end
            end
            VOTE: if (window_done) state_nxt = DECIDE;
            DECIDE: begin
               state_nxt = VOTE;
               if (want_up || want_dn) begin
                  lock_cnt_nxt = '0;
                  locked_nxt   = 1'b0;
                  // A step past either end of the chain is flagged, not taken.
                  if (want_up && tap_sel < TAP_MAX) begin
                     tap_nxt   = tap_sel + TAP_W'(1);
                     state_nxt = SETTLE;
                  end else if (want_dn && tap_sel != '0) begin
                     tap_nxt   = tap_sel - TAP_W'(1);
                     state_nxt = SETTLE;
                  end else begin
                     sat_nxt = 1'b1;
                  end
               end else begin
                  if (lock_cnt < LOCK_FULL) lock_cnt_nxt = lock_cnt + LW'(1);
                  if (lock_cnt_nxt == LOCK_FULL) locked_nxt = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
`ifdef DLL_TAP_OVERRIDE_EN
      if (tap_ovr_en) begin
         state_nxt    = IDLE;
         tap_nxt      = (tap_ovr_val > TAP_MAX) ? TAP_MAX : tap_ovr_val;
         locked_nxt   = 1'b0;
         lock_cnt_nxt = '0;
         settle_nxt   = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tap_sel    <= TAP_INIT;
         locked     <= 1'b0;
         busy       <= 1'b0;
         sat_err    <= 1'b0;
         lock_cnt   <= '0;
         settle_cnt <= '0;
      end else begin
         state      <= state_nxt;
         tap_sel    <= tap_nxt;
         locked     <= locked_nxt;
         busy       <= (state_nxt != IDLE);
         sat_err    <= sat_nxt;
         lock_cnt   <= lock_cnt_nxt;
         settle_cnt <= settle_nxt;
      end
   end

endmodule
